// File: rtl/terminal_writer.sv
// terminal_writer: byte-stream front end of the text terminal. Accepts characters
// over valid/ready, writes them into port B of the video RAM at the cursor, handles
// CR/LF/BS/FF, scrolls by copying rows up, and blanks the whole screen after reset.
//
// Handshake: a byte transfers on a rising clk36m edge where char_valid & char_ready
// are both high. char_ready is registered, only ever high in IDLE, and drops on the
// edge that accepts a byte; char_valid is ignored whenever char_ready is low.
module terminal_writer #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 25,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk36m,
  input  logic        reset_n,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [10:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic        vram_wren,
  input  logic [7:0]  vram_q,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam logic [10:0] L_COLS     = 11'(COLS);
  localparam logic [10:0] L_TOTAL    = 11'(COLS * ROWS);
  localparam logic [10:0] L_LAST     = 11'(COLS * ROWS - 1);
  localparam logic [10:0] L_LAST_ROW = 11'(COLS * (ROWS - 1));
  localparam logic [6:0]  L_MAX_COL  = 7'(COLS - 1);
  localparam logic [4:0]  L_MAX_ROW  = 5'(ROWS - 1);

  // CLEAR: r_idx is the next cell to blank; it equals L_TOTAL once every cell is issued.
  // SC_*: r_idx is the source cell of the copy in progress.
  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_IDLE   = 3'd1,
    S_WRITE  = 3'd2,
    S_SC_RD  = 3'd3,
    S_SC_LAT = 3'd4,
    S_SC_WR  = 3'd5,
    S_SC_CLR = 3'd6
  } state_t;

  state_t      r_state, w_state;
  logic [10:0] r_idx, w_idx;
  logic        r_ready, w_ready;
  logic [10:0] r_addr, w_addr;
  logic [7:0]  r_data, w_data;
  logic        r_wren, w_wren;
  logic [6:0]  r_col, w_col;
  logic [4:0]  r_row, w_row;
  logic        r_busy, w_busy;

  logic [10:0] w_cur_addr;
  logic        w_is_print;
  logic        w_xfer;

  assign w_cur_addr = ({6'd0, r_row} * L_COLS) + {4'd0, r_col};
  assign w_is_print = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign w_xfer     = char_valid & r_ready;

  assign char_ready = r_ready;
  assign vram_addr  = r_addr;
  assign vram_data  = r_data;
  assign vram_wren  = r_wren;
  assign cursor_col = r_col;
  assign cursor_row = r_row;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

  // Register the state and every output; reset aborts any clear/scroll at once.
  always_ff @(posedge clk36m or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_CLEAR;
      r_idx   <= 11'd0;
      r_ready <= 1'b0;
      r_addr  <= 11'd0;
      r_data  <= BLANK;
      r_wren  <= 1'b0;
      r_col   <= 7'd0;
      r_row   <= 5'd0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_ready <= w_ready;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_wren  <= w_wren;
      r_col   <= w_col;
      r_row   <= w_row;
      r_busy  <= w_busy;
    end
  end

  // Next state and next output values; wren defaults low so only write cycles raise it.
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_ready = r_ready;
    w_addr  = r_addr;
    w_data  = r_data;
    w_wren  = 1'b0;
    w_col   = r_col;
    w_row   = r_row;
    w_busy  = r_busy;

    case (r_state)
      S_CLEAR: begin
        if (r_idx == L_TOTAL) begin
          w_state = S_IDLE;
          w_ready = 1'b1;
          w_busy  = 1'b0;
          w_col   = 7'd0;
          w_row   = 5'd0;
          w_idx   = 11'd0;
        end else begin
          w_wren = 1'b1;
          w_addr = r_idx;
          w_data = BLANK;
          w_idx  = r_idx + 11'd1;
        end
      end

      S_IDLE: begin
        if (!r_ready) begin
          // Second cycle after a cursor-only byte: re-arm the handshake.
          w_ready = 1'b1;
        end else if (w_xfer) begin
          w_ready = 1'b0;
          if (w_is_print) begin
            w_state = S_WRITE;
            w_wren  = 1'b1;
            w_addr  = w_cur_addr;
            w_data  = char_data;
          end else begin
            case (char_data)
              8'h0D: w_col = 7'd0;
              8'h0A: begin
                if (r_row == L_MAX_ROW) begin
                  w_state = S_SC_RD;
                  w_busy  = 1'b1;
                  w_idx   = L_COLS;
                  w_addr  = L_COLS;
                end else begin
                  w_row = r_row + 5'd1;
                end
              end
              8'h08: begin
                if (r_col != 7'd0) w_col = r_col - 7'd1;
              end
              8'h0C: begin
                w_state = S_CLEAR;
                w_busy  = 1'b1;
                w_idx   = 11'd0;
              end
              default: ;
            endcase
          end
        end
      end

      S_WRITE: begin
        if (r_col == L_MAX_COL) begin
          w_col = 7'd0;
          if (r_row == L_MAX_ROW) begin
            w_state = S_SC_RD;
            w_busy  = 1'b1;
            w_idx   = L_COLS;
            w_addr  = L_COLS;
          end else begin
            w_row   = r_row + 5'd1;
            w_state = S_IDLE;
            w_ready = 1'b1;
          end
        end else begin
          w_col   = r_col + 7'd1;
          w_state = S_IDLE;
          w_ready = 1'b1;
        end
      end

      S_SC_RD: begin
        w_state = S_SC_LAT;
      end

      S_SC_LAT: begin
        // vram_q now holds the source byte; write it one row up.
        w_state = S_SC_WR;
        w_wren  = 1'b1;
        w_addr  = r_idx - L_COLS;
        w_data  = vram_q;
      end

      S_SC_WR: begin
        if (r_idx == L_LAST) begin
          w_state = S_SC_CLR;
          w_wren  = 1'b1;
          w_addr  = L_LAST_ROW;
          w_data  = BLANK;
        end else begin
          w_state = S_SC_RD;
          w_idx   = r_idx + 11'd1;
          w_addr  = r_idx + 11'd1;
        end
      end

      S_SC_CLR: begin
        if (r_addr == L_LAST) begin
          w_state = S_IDLE;
          w_ready = 1'b1;
          w_busy  = 1'b0;
        end else begin
          w_wren = 1'b1;
          w_addr = r_addr + 11'd1;
          w_data = BLANK;
        end
      end

      default: begin
        w_state = S_CLEAR;
        w_idx   = 11'd0;
        w_busy  = 1'b1;
        w_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_terminal_writer.sv
// tb_terminal_writer: drives bytes into terminal_writer, models the video RAM, and
// checks every RAM write and the cursor against a screen-level reference model.
module tb_terminal_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int CELLS = COLS * ROWS;

  logic        clk36m = 1'b0;
  logic        reset_n;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic [10:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_wren;
  logic [7:0]  vram_q;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;
  logic [2:0]  dbg_state;

  terminal_writer dut (
    .clk36m     (clk36m),
    .reset_n    (reset_n),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .vram_wren  (vram_wren),
    .vram_q     (vram_q),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk36m = ~clk36m;

  // ---------------- video RAM port B (one-cycle read latency) ----------------
  logic [7:0] mem [0:2047];
  always @(posedge clk36m) begin
    if (vram_wren) mem[vram_addr] <= vram_data;
    vram_q <= mem[vram_addr];
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: screen contents + cursor ----------------
  logic [18:0] exp_q[$];
  logic [7:0]  scr [0:CELLS-1];
  int          m_col;
  int          m_row;

  task automatic push_w(input int addr, input logic [7:0] d);
    exp_q.push_back({11'(addr), d});
  endtask

  task automatic model_clear();
    for (int a = 0; a < CELLS; a++) begin
      scr[a] = 8'h20;
      push_w(a, 8'h20);
    end
    m_col = 0;
    m_row = 0;
  endtask

  task automatic model_scroll();
    for (int d = 0; d < CELLS - COLS; d++) begin
      scr[d] = scr[d + COLS];
      push_w(d, scr[d]);
    end
    for (int d = CELLS - COLS; d < CELLS; d++) begin
      scr[d] = 8'h20;
      push_w(d, 8'h20);
    end
  endtask

  task automatic model_apply(input logic [7:0] b);
    int a;
    if (b >= 8'h20 && b <= 8'h7E) begin
      a = m_row * COLS + m_col;
      scr[a] = b;
      push_w(a, b);
      if (m_col == COLS - 1) begin
        m_col = 0;
        if (m_row == ROWS - 1) model_scroll();
        else m_row++;
      end else begin
        m_col++;
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      if (m_row == ROWS - 1) model_scroll();
      else m_row++;
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) begin
      model_clear();
    end
  endtask

  // ---------------- monitor: every RAM write must match the next expected one ----------------
  always @(negedge clk36m) begin
    if (reset_n === 1'b1 && vram_wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {13'd0, vram_addr, vram_data}, 32'hFFFF_FFFF);
      end else begin
        chk("vram_write", {13'd0, vram_addr, vram_data}, {13'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int budget, input string tag);
    int n = 0;
    while (char_ready !== 1'b1 && n < budget) begin
      @(negedge clk36m);
      n++;
    end
    if (char_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: char_ready=%b after %0d cycles, expected 1", tag, char_ready, n);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ready(8000, "send");
    model_apply(b);
    char_data  = b;
    char_valid = 1'b1;
    @(posedge clk36m);
    #1;
    char_valid = 1'b0;
    char_data  = 8'($urandom);
  endtask

  task automatic check_cursor(input string tag);
    chk({tag, "_col"}, {25'd0, cursor_col}, 32'(m_col));
    chk({tag, "_row"}, {27'd0, cursor_row}, 32'(m_row));
  endtask

  task automatic send_and_check(input logic [7:0] b, input string tag);
    send_byte(b);
    wait_ready(8000, tag);
    check_cursor(tag);
  endtask

  // Counts the unbroken run of write cycles that starts within a few cycles.
  task automatic count_wren_run(output int n);
    int guard = 0;
    n = 0;
    while (vram_wren !== 1'b1 && guard < 5) begin
      @(negedge clk36m);
      guard++;
    end
    while (vram_wren === 1'b1 && n < CELLS + 100) begin
      n++;
      @(negedge clk36m);
    end
  endtask

  function automatic logic [7:0] rand_other();
    logic [7:0] v;
    do begin
      v = 8'($urandom_range(0, 255));
    end while ((v >= 8'h20 && v <= 8'h7E) || v == 8'h08 || v == 8'h0A ||
               v == 8'h0C || v == 8'h0D);
    return v;
  endfunction

  function automatic int count_bad_ram();
    int bad = 0;
    for (int a = 0; a < CELLS; a++) if (mem[a] !== scr[a]) bad++;
    return bad;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          n;
    int          bad;
    int          busy_cycles;
    logic [2:0]  s_reset;
    logic [7:0]  b;
    int          r;

    reset_n    = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    m_col      = 0;
    m_row      = 0;

    // Reset values while reset_n is held low across a few edges.
    repeat (3) @(negedge clk36m);
    chk("rst_ready", {31'd0, char_ready}, 32'd0);
    chk("rst_wren",  {31'd0, vram_wren},  32'd0);
    chk("rst_addr",  {21'd0, vram_addr},  32'd0);
    chk("rst_data",  {24'd0, vram_data},  32'h20);
    chk("rst_busy",  {31'd0, busy},       32'd1);
    chk("rst_col",   {25'd0, cursor_col}, 32'd0);
    chk("rst_row",   {27'd0, cursor_row}, 32'd0);
    s_reset = dbg_state;

    // Power-up clear.
    model_clear();
    reset_n = 1'b1;
    count_wren_run(n);
    chk("clear_run_len", 32'(n), 32'(CELLS));
    wait_ready(10, "post_clear");
    chk("post_clear_busy", {31'd0, busy}, 32'd0);
    check_cursor("post_clear");
    chk("post_clear_drained", 32'(exp_q.size()), 32'd0);
    chk("dbg_state_left_clear", {31'd0, (dbg_state != s_reset)}, 32'd1);

    // Simple write, then CR with no write.
    send_and_check(8'h41, "char_A");
    send_and_check(8'h0D, "cr");
    chk("cr_no_write", 32'(exp_q.size()), 32'd0);

    // Reach (5,2) and write 'Z'; address must be 2*80+5.
    send_and_check(8'h0A, "lf1");
    send_and_check(8'h0A, "lf2");
    for (int i = 0; i < 5; i++) send_and_check(8'($urandom_range(32, 126)), "fill");
    send_byte(8'h5A);
    @(negedge clk36m);
    chk("z_wren", {31'd0, vram_wren}, 32'd1);
    chk("z_addr", {21'd0, vram_addr}, 32'd165);
    chk("z_data", {24'd0, vram_data}, 32'h5A);
    wait_ready(10, "z");
    check_cursor("z");

    // BS at column 0 does nothing; bell is ignored.
    send_and_check(8'h0D, "cr2");
    send_and_check(8'h08, "bs_col0");
    chk("bs_col0_col", {25'd0, cursor_col}, 32'd0);
    send_and_check(8'h07, "bell");
    chk("bell_no_write", 32'(exp_q.size()), 32'd0);

    // Randomized mix of printable, control and ignored bytes.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 11);
      if (r < 7)       b = 8'($urandom_range(32, 126));
      else if (r == 7) b = 8'h0D;
      else if (r == 8) b = 8'h0A;
      else if (r == 9) b = 8'h08;
      else             b = rand_other();
      send_and_check(b, "rand");
    end
    wait_ready(8000, "rand_end");
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_ram", 32'(count_bad_ram()), 32'd0);

    // FF at (10,10) with char_valid held high throughout the clear.
    send_byte(8'h0C);
    wait_ready(3000, "ff1");
    for (int i = 0; i < 10; i++) send_byte(8'h0A);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(32, 126)));
    wait_ready(100, "pos10");
    check_cursor("pos10");
    send_byte(8'h0C);
    char_data  = 8'h42;
    char_valid = 1'b1;
    n = 0;
    while (char_ready !== 1'b1 && n < CELLS + 100) begin
      @(negedge clk36m);
      n++;
    end
    chk("ff_ready_after_clear", {31'd0, char_ready}, 32'd1);
    chk("ff_busy", {31'd0, busy}, 32'd0);
    chk("ff_drained_before_accept", 32'(exp_q.size()), 32'd0);
    check_cursor("ff_end");
    model_apply(8'h42);
    @(posedge clk36m);
    #1;
    char_valid = 1'b0;
    wait_ready(10, "held_b");
    check_cursor("held_b");

    // Fill row r with 0x30+r up to (79,24), then 'X' forces a scroll.
    send_byte(8'h0C);
    for (int a = 0; a < CELLS - 1; a++) send_byte(8'(8'h30 + a / COLS));
    wait_ready(10, "fill_end");
    chk("fill_col", {25'd0, cursor_col}, 32'd79);
    chk("fill_row", {27'd0, cursor_row}, 32'd24);
    send_byte(8'h58);
    busy_cycles = 0;
    n = 0;
    while (char_ready !== 1'b1 && n < 7000) begin
      @(negedge clk36m);
      if (busy === 1'b1) busy_cycles++;
      n++;
    end
    chk("scroll_ready", {31'd0, char_ready}, 32'd1);
    chk("scroll_busy_cycles", 32'(busy_cycles), 32'd5840);
    chk("scroll_col", {25'd0, cursor_col}, 32'd0);
    chk("scroll_row", {27'd0, cursor_row}, 32'd24);
    chk("scroll_drained", 32'(exp_q.size()), 32'd0);
    bad = 0;
    for (int c = 0; c < COLS; c++) if (mem[c] !== 8'h31) bad++;
    chk("row0_bad", 32'(bad), 32'd0);
    bad = 0;
    for (int c = 0; c < COLS - 1; c++) if (mem[23 * COLS + c] !== 8'h48) bad++;
    chk("row23_bad", 32'(bad), 32'd0);
    chk("row23_x", {24'd0, mem[23 * COLS + 79]}, 32'h58);
    bad = 0;
    for (int c = 0; c < COLS; c++) if (mem[24 * COLS + c] !== 8'h20) bad++;
    chk("row24_bad", 32'(bad), 32'd0);
    chk("scroll_ram", 32'(count_bad_ram()), 32'd0);

    // Reset 100 cycles into an LF-triggered scroll.
    send_byte(8'h0A);
    repeat (100) @(negedge clk36m);
    n = 0;
    while (vram_wren !== 1'b1 && n < 5) begin
      @(negedge clk36m);
      n++;
    end
    chk("mid_scroll_wren_seen", {31'd0, vram_wren}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_wren", {31'd0, vram_wren}, 32'd0);
    chk("abort_ready", {31'd0, char_ready}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    exp_q.delete();
    model_clear();
    repeat (3) @(negedge clk36m);
    reset_n = 1'b1;
    count_wren_run(n);
    chk("reclear_run_len", 32'(n), 32'(CELLS));
    wait_ready(10, "reclear");
    chk("reclear_busy", {31'd0, busy}, 32'd0);
    check_cursor("reclear");
    chk("reclear_drained", 32'(exp_q.size()), 32'd0);
    chk("reclear_ram", 32'(count_bad_ram()), 32'd0);

    repeat (5) @(negedge clk36m);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
